mem_access_initiator: RTL and testbench

//  Initiator side of the data-memory request interface. Arbitrates fetch, load and store

---
 rtl/mem_access_initiator.sv | 162 ++++++++++++++++
 tb/tb_mem_access_initiator.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_initiator.sv
// Data-memory request initiator: arbitrates fetch/load/store clients onto edge-triggered
// memory request lines and returns captured (and extended) read results.
module mem_access_initiator #(
  parameter int unsigned PULSE_W      = 2,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_done,
  output logic [31:0] fetch_instr,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_type,
  output logic        ld_ready,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_type,
  output logic        st_ready,
  output logic        st_done,
  output logic        mem_inst_req,
  output logic [31:0] mem_inst_addr,
  input  logic [31:0] mem_instr,
  output logic        mem_load_req,
  output logic [31:0] mem_load_addr,
  input  logic [31:0] mem_load_data,
  output logic        mem_write_req,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_write_type
);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StWait, StDone} state_e;

  localparam logic [1:0] SelNone  = 2'd0;
  localparam logic [1:0] SelFetch = 2'd1;
  localparam logic [1:0] SelLoad  = 2'd2;
  localparam logic [1:0] SelStore = 2'd3;

  localparam logic [7:0] PulseLast = 8'(PULSE_W - 1);
  localparam logic [7:0] RdLast    = 8'(RD_LAT - 1);
  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, grant;
  logic [7:0]  cnt_q, starve_q;
  logic [2:0]  ld_type_q;
  logic [31:0] word_q, ld_ext;

  // A starved fetch overrides the normal store > load > fetch order.
  always_comb begin
    grant = SelNone;
    if (fetch_valid && starve_q == StarveMax) grant = SelFetch;
    else if (st_valid)                        grant = SelStore;
    else if (ld_valid)                        grant = SelLoad;
    else if (fetch_valid)                     grant = SelFetch;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant != SelNone) state_d = StSetup;
      StSetup: state_d = StPulse;
      StPulse: if (cnt_q == PulseLast) state_d = StWait;
      StWait:  if (sel_q == SelStore || cnt_q == RdLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request lines decode straight from state so an async reset drops them at once.
  always_comb begin
    fetch_ready   = 1'b0;
    ld_ready      = 1'b0;
    st_ready      = 1'b0;
    mem_inst_req  = 1'b0;
    mem_load_req  = 1'b0;
    mem_write_req = 1'b0;
    if (reset_n && state_q == StIdle) begin
      fetch_ready = (grant == SelFetch);
      ld_ready    = (grant == SelLoad);
      st_ready    = (grant == SelStore);
    end
    if (state_q == StPulse) begin
      mem_inst_req  = (sel_q == SelFetch);
      mem_load_req  = (sel_q == SelLoad);
      mem_write_req = (sel_q == SelStore);
    end
  end

  always_comb begin
    case (ld_type_q)
      3'b000:  ld_ext = {{24{word_q[7]}}, word_q[7:0]};
      3'b001:  ld_ext = {{16{word_q[15]}}, word_q[15:0]};
      3'b100:  ld_ext = {24'd0, word_q[7:0]};
      3'b101:  ld_ext = {16'd0, word_q[15:0]};
      default: ld_ext = word_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q          <= SelNone;
      cnt_q          <= '0;
      starve_q       <= '0;
      ld_type_q      <= '0;
      word_q         <= '0;
      fetch_done     <= 1'b0;
      ld_done        <= 1'b0;
      st_done        <= 1'b0;
      fetch_instr    <= '0;
      ld_data        <= '0;
      mem_inst_addr  <= '0;
      mem_load_addr  <= '0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      mem_write_type <= '0;
    end else begin
      cnt_q      <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
      fetch_done <= (state_q == StDone) && (sel_q == SelFetch);
      ld_done    <= (state_q == StDone) && (sel_q == SelLoad);
      st_done    <= (state_q == StDone) && (sel_q == SelStore);
      if (state_q == StIdle && grant != SelNone) begin
        sel_q <= grant;
        case (grant)
          SelFetch: mem_inst_addr <= fetch_addr;
          SelLoad: begin
            mem_load_addr <= ld_addr;
            ld_type_q     <= ld_type;
          end
          SelStore: begin
            mem_write_addr <= st_addr;
            mem_write_data <= st_data;
            mem_write_type <= st_type;
          end
          default: ;
        endcase
        if (grant == SelFetch || !fetch_valid) starve_q <= 8'd0;
        else if (starve_q < StarveMax)         starve_q <= starve_q + 8'd1;
      end
      if (state_q == StWait && state_d == StDone && sel_q != SelStore) begin
        word_q <= (sel_q == SelFetch) ? mem_instr : mem_load_data;
      end
      if (state_q == StDone) begin
        if (sel_q == SelFetch) fetch_instr <= word_q;
        if (sel_q == SelLoad)  ld_data     <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Scoreboard bench for mem_access_initiator: client tasks queue expected results at grant,
// a negedge monitor pops and compares on each done pulse and watches the request lines.
module tb_mem_access_initiator;
  localparam int unsigned PW = 2;
  localparam int unsigned RL = 1;
  localparam int unsigned SL = 4;
  localparam int LAT_RD = 3 + PW + RL;
  localparam int LAT_ST = 4 + PW;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        fetch_valid, fetch_ready, fetch_done;
  logic [31:0] fetch_addr, fetch_instr;
  logic        ld_valid, ld_ready, ld_done;
  logic [31:0] ld_addr, ld_data;
  logic [2:0]  ld_type;
  logic        st_valid, st_ready, st_done;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_type;
  logic        mem_inst_req, mem_load_req, mem_write_req;
  logic [31:0] mem_inst_addr, mem_instr, mem_load_addr, mem_load_data;
  logic [31:0] mem_write_addr, mem_write_data;
  logic [2:0]  mem_write_type;

  mem_access_initiator #(.PULSE_W(PW), .RD_LAT(RL), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_done(fetch_done), .fetch_instr(fetch_instr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
    .st_ready(st_ready), .st_done(st_done),
    .mem_inst_req(mem_inst_req), .mem_inst_addr(mem_inst_addr), .mem_instr(mem_instr),
    .mem_load_req(mem_load_req), .mem_load_addr(mem_load_addr),
    .mem_load_data(mem_load_data), .mem_write_req(mem_write_req),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_type(mem_write_type)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
    int          rc;
  } txn_t;
  txn_t  fq[$], lq[$], sq[$];
  string glog;

  logic        fix_i_en = 1'b0, fix_d_en = 1'b0;
  logic [31:0] fix_i = '0, fix_d = '0;

  function automatic logic [31:0] ihash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] dhash(input logic [31:0] a);
    return (a * 32'h85EBCA6B) + 32'h01234567;
  endfunction

  // Behavioural memory: read word is a fixed function of the presented address.
  assign mem_instr     = fix_i_en ? fix_i : ihash(mem_inst_addr);
  assign mem_load_data = fix_d_en ? fix_d : dhash(mem_load_addr);

  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] t);
    logic [31:0] v;
    if (t == 3'd0 || t == 3'd4) begin
      v = w % 256;
      if (t == 3'd0 && v >= 128) v = v - 32'd256;
    end else if (t == 3'd1 || t == 3'd5) begin
      v = w % 65536;
      if (t == 3'd1 && v >= 32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out at cycle %0d", name, cyc);
  endtask

  task automatic fetch_req(input logic [31:0] a, input logic [31:0] w);
    bit   got = 0;
    txn_t t;
    fetch_addr = a;
    fetch_valid = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clock);
      if (fetch_ready) got = 1;
    end
    if (!got) timeout_fail("fetch_ready");
    else begin
      t.addr = a; t.data = w; t.typ = 3'd0; t.rc = cyc;
      fq.push_back(t);
      glog = {glog, "F"};
    end
    @(posedge clock); #1;
    fetch_valid = 1'b0;
  endtask

  task automatic ld_req(input logic [31:0] a, input logic [2:0] ty, input logic [31:0] exp);
    bit   got = 0;
    txn_t t;
    ld_addr = a;
    ld_type = ty;
    ld_valid = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clock);
      if (ld_ready) got = 1;
    end
    if (!got) timeout_fail("ld_ready");
    else begin
      t.addr = a; t.data = exp; t.typ = ty; t.rc = cyc;
      lq.push_back(t);
      glog = {glog, "L"};
    end
    @(posedge clock); #1;
    ld_valid = 1'b0;
  endtask

  task automatic st_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ty);
    bit   got = 0;
    txn_t t;
    st_addr = a;
    st_data = d;
    st_type = ty;
    st_valid = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clock);
      if (st_ready) got = 1;
    end
    if (!got) timeout_fail("st_ready");
    else begin
      t.addr = a; t.data = d; t.typ = ty; t.rc = cyc;
      sq.push_back(t);
      glog = {glog, "S"};
    end
    @(posedge clock); #1;
    st_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clock);
      if (fq.size() == 0 && lq.size() == 0 && sq.size() == 0) ok = 1;
    end
    if (!ok) timeout_fail("drain");
    @(posedge clock); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {23'd0, fetch_ready, fetch_done, ld_ready, ld_done, st_ready, st_done,
                           mem_inst_req, mem_load_req, mem_write_req}, 32'd0);
    check({tag, "_addr"}, mem_inst_addr | mem_load_addr | mem_write_addr | mem_write_data, 32'd0);
    check({tag, "_res"}, fetch_instr | ld_data | {29'd0, mem_write_type}, 32'd0);
  endtask

  // Monitor: scoreboard pops on done pulses, plus request-line protocol checks.
  logic        pi = 0, pl = 0, pw = 0;
  logic [31:0] pia = 0, pla = 0, pwa = 0;
  int          ri = 0, rl = 0, rw = 0;
  always @(negedge clock) begin
    txn_t e;
    if (!reset_n) begin
      pi = 0; pl = 0; pw = 0; ri = 0; rl = 0; rw = 0;
    end else begin
      total++;
      if (int'(mem_inst_req) + int'(mem_load_req) + int'(mem_write_req) > 1) begin
        bad++;
        $display("FAIL req_onehot actual=%b%b%b required=at most one high",
                 mem_inst_req, mem_load_req, mem_write_req);
      end
      if (mem_inst_req && fq.size() > 0) begin
        check("inst_addr", mem_inst_addr, fq[0].addr);
        if (!pi) check("inst_setup_addr", pia, fq[0].addr);
      end
      if (mem_load_req && lq.size() > 0) begin
        check("load_addr", mem_load_addr, lq[0].addr);
        if (!pl) check("load_setup_addr", pla, lq[0].addr);
      end
      if (mem_write_req && sq.size() > 0) begin
        check("write_addr", mem_write_addr, sq[0].addr);
        check("write_data", mem_write_data, sq[0].data);
        check("write_type", {29'd0, mem_write_type}, {29'd0, sq[0].typ});
        if (!pw) check("write_setup_addr", pwa, sq[0].addr);
      end
      if (mem_inst_req) ri++;
      else if (pi) begin check("inst_pulse_w", ri, PW); ri = 0; end
      if (mem_load_req) rl++;
      else if (pl) begin check("load_pulse_w", rl, PW); rl = 0; end
      if (mem_write_req) rw++;
      else if (pw) begin check("write_pulse_w", rw, PW); rw = 0; end
      if (fetch_done) begin
        if (fq.size() == 0) timeout_fail("fetch_done_spurious");
        else begin
          e = fq.pop_front();
          check("fetch_instr", fetch_instr, e.data);
          check("fetch_latency", cyc - e.rc, LAT_RD);
        end
      end
      if (ld_done) begin
        if (lq.size() == 0) timeout_fail("ld_done_spurious");
        else begin
          e = lq.pop_front();
          check("ld_data", ld_data, e.data);
          check("ld_latency", cyc - e.rc, LAT_RD);
        end
      end
      if (st_done) begin
        if (sq.size() == 0) timeout_fail("st_done_spurious");
        else begin
          e = sq.pop_front();
          check("st_latency", cyc - e.rc, LAT_ST);
        end
      end
      pi = mem_inst_req; pl = mem_load_req; pw = mem_write_req;
      pia = mem_inst_addr; pla = mem_load_addr; pwa = mem_write_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [2:0] ld_types [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

  initial begin
    bit got;
    fetch_valid = 0; fetch_addr = '0;
    ld_valid = 0; ld_addr = '0; ld_type = '0;
    st_valid = 0; st_addr = '0; st_data = '0; st_type = '0;
    glog = "";
    repeat (3) @(posedge clock);
    #1 check_outputs_zero("reset");
    @(posedge clock); #1 reset_n = 1'b1;

    fix_i_en = 1; fix_i = 32'h00A00093;
    fetch_req(32'h100, 32'h00A00093);
    drain();

    fix_d_en = 1; fix_d = 32'h11223380;
    ld_req(32'h1000, 3'b000, 32'hFFFFFF80); drain();
    ld_req(32'h1000, 3'b100, 32'h00000080); drain();
    fix_d = 32'h1234F00D;
    ld_req(32'h1000, 3'b001, 32'hFFFFF00D); drain();
    ld_req(32'h1000, 3'b101, 32'h0000F00D); drain();
    ld_req(32'h1000, 3'b010, 32'h1234F00D); drain();
    ld_req(32'h1000, 3'b011, 32'h1234F00D); drain();

    st_req(32'h104, 32'h41, 3'b010);
    drain();

    glog = "";
    fork
      st_req(32'h300, 32'hDEADBEEF, 3'b000);
      ld_req(32'h304, 3'b010, 32'h1234F00D);
      fetch_req(32'h308, 32'h00A00093);
    join
    drain();
    total++;
    if (glog != "SLF") begin bad++; $display("FAIL grant_order actual=%s required=SLF", glog); end

    glog = "";
    fork
      begin
        fetch_req(32'h400, 32'h00A00093);
        fetch_req(32'h404, 32'h00A00093);
      end
      for (int i = 0; i < 9; i++) ld_req(32'h500 + 32'(4 * i), 3'b010, 32'h1234F00D);
    join
    drain();
    total++;
    if (glog != "LLLLFLLLLFL") begin
      bad++;
      $display("FAIL starve_order actual=%s required=LLLLFLLLLFL", glog);
    end

    fix_i = 32'hCAFEF00D;
    fetch_req(32'h200, 32'hCAFEF00D);
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clock);
      if (mem_inst_req) got = 1;
    end
    check("pre_reset_req", {31'd0, mem_inst_req}, 32'd1);
    #1 reset_n = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr = 32'h200;
    #1 check_outputs_zero("midop_reset");
    fq.delete(); lq.delete(); sq.delete();
    repeat (2) begin
      @(negedge clock);
      check("in_reset_quiet", {28'd0, fetch_ready, fetch_done, mem_inst_req, ld_done}, 32'd0);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    fetch_req(32'h200, 32'hCAFEF00D);
    drain();

    fix_i_en = 0; fix_d_en = 0;
    fork
      for (int i = 0; i < 15; i++) begin
        logic [31:0] a;
        a = $urandom;
        repeat ($urandom_range(0, 6)) @(posedge clock);
        #1 fetch_req(a, ihash(a));
      end
      for (int i = 0; i < 15; i++) begin
        logic [31:0] a;
        logic [2:0]  t;
        a = $urandom;
        t = ld_types[$urandom_range(0, 6)];
        repeat ($urandom_range(0, 6)) @(posedge clock);
        #1 ld_req(a, t, ext_model(dhash(a), t));
      end
      for (int i = 0; i < 15; i++) begin
        logic [31:0] a, d;
        logic [2:0]  t;
        a = $urandom;
        d = $urandom;
        t = 3'($urandom_range(0, 2));
        repeat ($urandom_range(0, 8)) @(posedge clock);
        #1 st_req(a, d, t);
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
